// File: rtl/operator_sequencer.sv
// Operator issue sequencer: sweeps voice-operator IDs once per sample frame and
// drains queued host config writes into the modulator only while nothing is issued.
module operator_sequencer #(
    parameter int NUM_VOICE_OPERATORS = 256,
    parameter int ID_WIDTH            = 8,
    parameter int GAP_CYCLES          = 8,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_Enable,
    output logic                          o_IssueValid,
    output logic [ID_WIDTH-1:0]           o_VoiceOperator,
    output logic                          o_FrameStart,
    output logic                          o_FrameDone,
    input  logic                          i_CfgValid,
    output logic                          o_CfgReady,
    input  logic [ID_WIDTH-1:0]           i_CfgAddr,
    input  logic [15:0]                   i_CfgData,
    output logic                          o_AlgorithmWriteEnable,
    output logic [ID_WIDTH-1:0]           o_ConfigWriteAddr,
    output logic [15:0]                   o_ConfigWriteData,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NUM_VOICE_OPERATORS - 1);
    localparam logic [GAP_W-1:0]    LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] id_nxt, id_inc;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt;
    logic                issue_nxt, start_nxt, done_nxt;

    // ---------------- frame FSM ----------------
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    assign id_inc = o_VoiceOperator + 1'b1;

    // Issue outputs are computed one cycle ahead so they leave straight from flops.
    always_comb begin
        state_nxt = state;
        id_nxt    = o_VoiceOperator;
        gap_nxt   = gap_cnt;
        issue_nxt = 1'b0;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_Enable) begin
                    state_nxt = RUN;
                    id_nxt    = '0;
                    issue_nxt = 1'b1;
                    start_nxt = 1'b1;
                    done_nxt  = (LAST_ID == '0);
                end
            end
            RUN: begin
                if (o_VoiceOperator == LAST_ID) begin
                    state_nxt = GAP;
                    id_nxt    = '0;
                    gap_nxt   = '0;
                end else begin
                    id_nxt    = id_inc;
                    issue_nxt = 1'b1;
                    done_nxt  = (id_inc == LAST_ID);
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    gap_nxt = '0;
                    if (i_Enable) begin
                        state_nxt = RUN;
                        id_nxt    = '0;
                        issue_nxt = 1'b1;
                        start_nxt = 1'b1;
                        done_nxt  = (LAST_ID == '0);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_IssueValid    <= 1'b0;
            o_VoiceOperator <= '0;
            o_FrameStart    <= 1'b0;
            o_FrameDone     <= 1'b0;
        end else begin
            o_IssueValid    <= issue_nxt;
            o_VoiceOperator <= id_nxt;
            o_FrameStart    <= start_nxt;
            o_FrameDone     <= done_nxt;
        end
    end

    // ---------------- config write queue ----------------
    logic [ID_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [15:0]         data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr, rd_nxt;
    logic [LVL_W-1:0]    level, level_nxt, remain;
    logic                push, pop, drain_nxt;
    logic [ID_WIDTH-1:0] head_addr_nxt;
    logic [15:0]         head_data_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready ignores a same-cycle pop so a full queue never accepts.
    assign o_CfgReady = (level < LVL_W'(FIFO_DEPTH));
    assign push       = i_CfgValid && o_CfgReady;
    assign pop        = o_AlgorithmWriteEnable;
    assign o_FifoLevel = level;

    // The entry on the write port stays counted until the end of its strobe cycle.
    always_comb begin
        rd_nxt        = pop ? ptr_inc(rd_ptr) : rd_ptr;
        remain        = level - LVL_W'(pop);
        level_nxt     = remain + LVL_W'(push);
        head_addr_nxt = (remain == '0) ? i_CfgAddr : addr_mem[rd_nxt];
        head_data_nxt = (remain == '0) ? i_CfgData : data_mem[rd_nxt];
        drain_nxt     = (state_nxt != RUN) && (level_nxt != '0);
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= i_CfgAddr;
            data_mem[wr_ptr] <= i_CfgData;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            level  <= level_nxt;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_AlgorithmWriteEnable <= 1'b0;
            o_ConfigWriteAddr      <= '0;
            o_ConfigWriteData      <= '0;
        end else begin
            o_AlgorithmWriteEnable <= drain_nxt;
            if (drain_nxt) begin
                o_ConfigWriteAddr <= head_addr_nxt;
                o_ConfigWriteData <= head_data_nxt;
            end
        end
    end

endmodule

// File: doc/operator_sequencer.md
OPERATOR_SEQUENCER -- requirements
Module: operator_sequencer

Interface
REQ-001 SHALL have parameter NUM_VOICE_OPERATORS, default 256: voice-operator slots per sample frame.
REQ-002 SHALL have parameter ID_WIDTH, default 8: width of VoiceOperatorID_t; 2**ID_WIDTH >= NUM_VOICE_OPERATORS.
REQ-003 SHALL have parameter GAP_CYCLES, default 8 (>=1): idle cycles after each frame, covering the modulator pipeline depth.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two): config write queue depth.
REQ-005 Ports (name  direction  width  meaning):
- i_Clock  in  1  sole clock; rising edge.
- i_Reset_n  in  1  reset; one clock, asynchronous, active-low.
- i_Enable  in  1  run frames continuously while high.
- o_IssueValid  out  1  o_VoiceOperator is a valid issue slot.
- o_VoiceOperator  out  ID_WIDTH  voice-operator ID fed to modulator stage.
- o_FrameStart  out  1  pulse with ID 0 issue.
- o_FrameDone  out  1  pulse with ID NUM_VOICE_OPERATORS-1 issue.
- i_CfgValid  in  1  host config write request.
- o_CfgReady  out  1  queue accepts request.
- i_CfgAddr  in  ID_WIDTH  target voice-operator.
- i_CfgData  in  16  algorithm word (bits 10:0 used downstream).
- o_AlgorithmWriteEnable  out  1  one-cycle write strobe to modulator.
- o_ConfigWriteAddr  out  ID_WIDTH  write address.
- o_ConfigWriteData  out  16  write data.
- o_FifoLevel  out  log2(FIFO_DEPTH)+1  queued entry count.

Function
REQ-006 SHALL implement states IDLE, RUN, GAP, held in a state register; all outputs except o_CfgReady SHALL come directly from registers.
REQ-007 IDLE: o_IssueValid=0; on i_Enable=1 at a clock edge, next state RUN with issue counter 0.
REQ-008 RUN: every cycle o_IssueValid=1, o_VoiceOperator=counter; counter increments by 1 per cycle.
REQ-009 o_FrameStart=1 exactly in the cycle ID 0 is issued; o_FrameDone=1 exactly in the cycle ID NUM_VOICE_OPERATORS-1 is issued; both 0 otherwise.
REQ-010 After issuing ID NUM_VOICE_OPERATORS-1, next state GAP; counter wraps to 0; no IDs >= NUM_VOICE_OPERATORS ever issued.
REQ-011 i_Enable deasserted during RUN SHALL NOT truncate the frame; the frame completes and enters GAP.
REQ-012 GAP lasts exactly GAP_CYCLES cycles with o_IssueValid=0; at its end: i_Enable=1 -> RUN (ID 0 next cycle), else IDLE.
REQ-013 Back-to-back frames: ID N-1 issue, then GAP_CYCLES invalid cycles, then ID 0.
REQ-014 o_CfgReady = (level < FIFO_DEPTH), combinational; push when i_CfgValid && o_CfgReady.
REQ-015 Drain: in a cycle where state is IDLE or GAP and FIFO non-empty, o_AlgorithmWriteEnable=1 with head addr/data, entry popped at that cycle's end; at most one write per cycle.
REQ-016 o_AlgorithmWriteEnable SHALL never be 1 in a cycle with o_IssueValid=1.
REQ-017 No write-through: a request accepted at edge k SHALL appear on o_AlgorithmWriteEnable no earlier than cycle after edge k.
REQ-018 Simultaneous push and pop: level unchanged, order preserved (FIFO order strictly).
REQ-019 Full FIFO: o_CfgReady=0 even if a pop occurs the same cycle; host request held, not lost.
REQ-020 o_ConfigWriteAddr/Data hold last written values when strobe is 0.

Reset
REQ-021 Asserting i_Reset_n=0 SHALL immediately force: state IDLE, counters 0, FIFO empty, o_IssueValid/o_FrameStart/o_FrameDone/o_AlgorithmWriteEnable=0, o_VoiceOperator=0, o_ConfigWriteAddr/Data=0, o_FifoLevel=0, o_CfgReady=1.
REQ-022 Reset mid-frame or mid-drain SHALL discard queued writes and the partial frame; after release, first frame starts with ID 0.

Verification
REQ-023 Enable held 1, N=256, GAP=8: IDs 0..255 consecutive, FrameStart with 0, FrameDone with 255, 8 invalid cycles, then ID 0 again.
REQ-024 Enable dropped at ID 100: IDs 101..255 still issued, 8 GAP cycles, then IDLE with o_IssueValid=0.
REQ-025 Push 6 writes during RUN (addr 1..6): first 4 accepted, o_CfgReady=0 thereafter; no strobe during RUN; GAP drains addr 1..4 one per cycle in order; remaining 2 accepted and drained in same GAP.
REQ-026 IDLE, single push addr 0x12 data 0x07FF at edge k: strobe in cycle after k with those values; level returns to 0.
REQ-027 Push and pop same cycle at level 2 in GAP: level stays 2, data order preserved.
REQ-028 Reset asserted asynchronously mid-RUN with 3 queued writes: outputs zero without clock edge, level 0, no strobe after release; enable -> ID 0 first.
